// File: rtl/word_banner_pkg.sv
// word_banner_pkg: shared types and the banner word table.
//   state_t    - banner controller states
//   word_id_t  - banner word selector (W_NONE is the blank/reserved word)
//   word_len   - characters in a word
//   word_char  - font code of character idx of a word (0 past the end)
package word_banner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REVEAL,
        HOLD,
        BLINK
    } state_t;

    typedef enum logic [1:0] {
        W_FIGHT,
        W_DEFEAT,
        W_VICTORY,
        W_NONE
    } word_id_t;

    localparam logic [9:0] CHAR_BANG = 10'h03F;
    localparam logic [9:0] CHAR_A    = 10'h00A;

    function automatic logic [3:0] word_len(word_id_t w);
        case (w)
            W_FIGHT:   return 4'd6;
            W_DEFEAT:  return 4'd7;
            W_VICTORY: return 4'd8;
            default:   return 4'd0;
        endcase
    endfunction

    // Words are kept as ASCII so the table reads like the text on screen.
    function automatic logic [7:0] word_ascii(word_id_t w, logic [3:0] idx);
        logic [7:0] c;
        c = 8'h00;
        case (w)
            W_FIGHT: begin
                case (idx)
                    4'd0: c = "F";
                    4'd1: c = "I";
                    4'd2: c = "G";
                    4'd3: c = "H";
                    4'd4: c = "T";
                    4'd5: c = "!";
                    default: c = 8'h00;
                endcase
            end
            W_DEFEAT: begin
                case (idx)
                    4'd0: c = "D";
                    4'd1: c = "E";
                    4'd2: c = "F";
                    4'd3: c = "E";
                    4'd4: c = "A";
                    4'd5: c = "T";
                    4'd6: c = "!";
                    default: c = 8'h00;
                endcase
            end
            W_VICTORY: begin
                case (idx)
                    4'd0: c = "V";
                    4'd1: c = "I";
                    4'd2: c = "C";
                    4'd3: c = "T";
                    4'd4: c = "O";
                    4'd5: c = "R";
                    4'd6: c = "Y";
                    4'd7: c = "!";
                    default: c = 8'h00;
                endcase
            end
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [9:0] word_char(word_id_t w, logic [3:0] idx);
        logic [7:0] c;
        c = word_ascii(w, idx);
        if (idx >= word_len(w)) begin
            return 10'h000;
        end
        if (c == "!") begin
            return CHAR_BANG;
        end
        return CHAR_A + {2'b00, c - 8'h41};
    endfunction

endpackage

// File: rtl/word_banner_if.sv
// word_banner_if: control and pixel bus between the game-state controller /
// font pipeline (master) and the banner (slave).
//   show, hide, word_sel   - banner control
//   DrawX, DrawY           - current pixel
//   start_x, start_y, n,
//   is_word                - font pipeline contract
//   busy, reveal_done      - status back to the controller
interface word_banner_if;
    logic       show;
    logic       hide;
    logic [1:0] word_sel;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [9:0] start_x;
    logic [9:0] start_y;
    logic [9:0] n;
    logic       is_word;
    logic       busy;
    logic       reveal_done;

    modport master (
        output show, hide, word_sel, DrawX, DrawY,
        input  start_x, start_y, n, is_word, busy, reveal_done
    );

    modport slave (
        input  show, hide, word_sel, DrawX, DrawY,
        output start_x, start_y, n, is_word, busy, reveal_done
    );
endinterface

// File: rtl/word_banner_frame_tick.sv
// frame_tick_detect: turns the vertical-sync-rate frame_clk into a one-cycle
// tick in the Clk domain, asserted the cycle after a rising edge is seen.
//   Clk, Reset - system clock, async active-high reset
//   frame_clk  - frame-rate level signal
//   tick       - one-cycle pulse per frame_clk rising edge
module frame_tick_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic frame_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            frame_q <= frame_clk;
            tick    <= frame_clk & ~frame_q;
        end
    end
endmodule

// File: rtl/word_banner.sv
// word_banner: typewriter-style banner overlay. Latches a word on show,
// reveals one character every REVEAL_FRAMES frame ticks, holds for
// HOLD_FRAMES ticks, then blinks with a BLINK_FRAMES half-period until hide.
//   Clk, Reset - system clock, async active-high reset
//   frame_clk  - frame-rate signal, rising edge = one frame tick
//   bus        - control, pixel position and font-pipeline outputs
//
// state  | meaning
// IDLE   | nothing shown
// REVEAL | characters appearing one by one
// HOLD   | whole word shown, waiting to start blinking
// BLINK  | whole word blinking
module word_banner
    import word_banner_pkg::*;
#(
    parameter int X_START       = 200,
    parameter int Y_START       = 400,
    parameter int CHAR_W        = 8,
    parameter int CHAR_H        = 16,
    parameter int MAX_LEN       = 8,
    parameter int REVEAL_FRAMES = 4,
    parameter int HOLD_FRAMES   = 60,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_clk,
    word_banner_if.slave bus
);
    localparam int CNT_MAX = (REVEAL_FRAMES > HOLD_FRAMES)
        ? ((REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES)
        : ((HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_LEN + 1);
    localparam int CHAR_SH = $clog2(CHAR_W);

    localparam logic [CNT_W-1:0] REVEAL_LAST = CNT_W'(REVEAL_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   =
        CNT_W'((HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0);
    localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);

    state_t           state_q,  state_d;
    word_id_t         word_q,   word_d;
    logic [RW-1:0]    reveal_q, reveal_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_q,  blink_d;
    logic             reveal_done_c;
    logic             tick;
    logic [RW-1:0]    len_eff;
    logic [3:0]       len_raw;

    frame_tick_detect u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Clamp to MAX_LEN so the box never grows past its ceiling.
    always_comb begin
        len_raw = word_len(word_q);
        len_eff = (int'(len_raw) > MAX_LEN) ? RW'(MAX_LEN) : RW'(len_raw);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            word_q      <= W_NONE;
            reveal_q    <= '0;
            frame_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            reveal_q    <= reveal_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // hide beats show; show beats any tick in the same cycle.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        reveal_d      = reveal_q;
        frame_cnt_d   = frame_cnt_q;
        blink_d       = blink_q;
        reveal_done_c = 1'b0;

        if (bus.hide) begin
            state_d     = IDLE;
            reveal_d    = '0;
            frame_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (bus.show) begin
            word_d      = word_id_t'(bus.word_sel);
            frame_cnt_d = '0;
            blink_d     = 1'b1;
            if (word_len(word_id_t'(bus.word_sel)) == 4'd0) begin
                state_d  = IDLE;
                reveal_d = '0;
            end else begin
                state_d  = REVEAL;
                reveal_d = RW'(1);
            end
        end else begin
            case (state_q)
                REVEAL: begin
                    if (reveal_q >= len_eff) begin
                        reveal_done_c = 1'b1;
                        frame_cnt_d   = '0;
                        state_d       = HOLD;
                    end else if (tick) begin
                        if (frame_cnt_q == REVEAL_LAST) begin
                            reveal_d    = reveal_q + 1'b1;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // The word turns dark on the same tick that ends HOLD.
                    if (HOLD_FRAMES != 0 && tick) begin
                        if (frame_cnt_q == HOLD_LAST) begin
                            state_d     = BLINK;
                            blink_d     = 1'b0;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
                BLINK: begin
                    if (tick) begin
                        if (frame_cnt_q == BLINK_LAST) begin
                            blink_d     = ~blink_q;
                            frame_cnt_d = '0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    logic [10:0] x_ext, y_ext, x_end;
    logic [9:0]  col;
    logic        in_x, in_y;

    // 11-bit box math keeps X_START + width from wrapping at 1024.
    always_comb begin
        x_ext = {1'b0, bus.DrawX};
        y_ext = {1'b0, bus.DrawY};
        x_end = 11'(X_START) + (11'(len_eff) << CHAR_SH);
        in_x  = (x_ext >= 11'(X_START)) && (x_ext < x_end);
        in_y  = (y_ext >= 11'(Y_START)) && (y_ext < 11'(Y_START + CHAR_H));
        col   = (bus.DrawX - 10'(X_START)) >> CHAR_SH;
    end

    assign bus.start_x     = 10'(X_START);
    assign bus.start_y     = 10'(Y_START);
    assign bus.n           = (col < 10'(len_eff)) ? word_char(word_q, col[3:0]) : 10'h000;
    assign bus.busy        = (state_q != IDLE);
    assign bus.is_word     = in_x && in_y && (col < 10'(reveal_q)) && blink_q
                             && (state_q != IDLE);
    assign bus.reveal_done = reveal_done_c;

endmodule

// File: tb/tb_word_banner.sv
module tb_word_banner;
    localparam int XS = 200;
    localparam int YS = 400;
    localparam int RF = 4;
    localparam int HF = 60;
    localparam int BF = 30;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic frame_clk = 1'b0;

    word_banner_if bus ();

    word_banner #(
        .X_START(XS), .Y_START(YS), .CHAR_W(8), .CHAR_H(16), .MAX_LEN(8),
        .REVEAL_FRAMES(RF), .HOLD_FRAMES(HF), .BLINK_FRAMES(BF)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit check_en = 1'b0;

    // Model: word shown, whether a banner is up, frame ticks since show.
    string words [4] = '{"FIGHT!", "DEFEAT!", "VICTORY!", ""};
    int  m_word  = 3;
    bit  m_busy  = 1'b0;
    int  m_ticks = 0;

    function automatic int m_len();
        return words[m_word].len();
    endfunction

    function automatic int code_of(int w, int i);
        byte c;
        c = words[w].getc(i);
        if (c == "!") return 'h3F;
        return 'h0A + (c - "A");
    endfunction

    function automatic int m_revealed();
        int r;
        if (!m_busy) return 0;
        r = 1 + m_ticks / RF;
        if (r > m_len()) r = m_len();
        return r;
    endfunction

    function automatic bit m_on();
        int t;
        if (m_revealed() < m_len()) return 1'b1;
        t = m_ticks - (m_len() - 1) * RF;
        if (t < HF) return 1'b1;
        return (((t - HF) / BF) % 2) == 1;
    endfunction

    function automatic bit exp_is_word(int x, int y);
        if (!m_busy || !m_on()) return 1'b0;
        if (x < XS || x >= XS + m_len() * 8) return 1'b0;
        if (y < YS || y >= YS + 16) return 1'b0;
        return ((x - XS) / 8) < m_revealed();
    endfunction

    function automatic int exp_n(int x);
        int c;
        if (x < XS) return 0;
        c = (x - XS) / 8;
        if (c >= m_len()) return 0;
        return code_of(m_word, c);
    endfunction

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge Clk);
            if (check_en) begin
                int xi;
                int yi;
                xi = int'(bus.DrawX);
                yi = int'(bus.DrawY);
                checks++;
                if (bus.is_word !== exp_is_word(xi, yi)) begin
                    errors++;
                    $display("FAIL cmp_is_word x=%0d y=%0d got %b want %b", xi, yi,
                             bus.is_word, exp_is_word(xi, yi));
                end
                checks++;
                if (bus.n !== 10'(exp_n(xi))) begin
                    errors++;
                    $display("FAIL cmp_n x=%0d got %h want %h", xi, bus.n, exp_n(xi));
                end
                checks++;
                if (bus.busy !== m_busy) begin
                    errors++;
                    $display("FAIL cmp_busy got %b want %b", bus.busy, m_busy);
                end
                checks++;
                if (bus.start_x !== 10'(XS) || bus.start_y !== 10'(YS)) begin
                    errors++;
                    $display("FAIL cmp_start got %0d,%0d want %0d,%0d",
                             bus.start_x, bus.start_y, XS, YS);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (bus.reveal_done === 1'b1) done_cnt++;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge Clk);
        #1;
    endtask

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic pix(input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        #1;
    endtask

    task automatic do_tick();
        check_en = 1'b0;
        frame_clk = 1'b1;
        cyc(3);
        m_ticks++;
        frame_clk = 1'b0;
        cyc(1);
        check_en = 1'b1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) do_tick();
    endtask

    task automatic do_show(input int sel);
        check_en = 1'b0;
        bus.word_sel = 2'(sel);
        bus.show = 1'b1;
        cyc(1);
        bus.show = 1'b0;
        m_word = sel;
        m_busy = (words[sel].len() != 0);
        m_ticks = 0;
        cyc(1);
        check_en = 1'b1;
    endtask

    task automatic sweep();
        int xs [13] = '{196, 200, 207, 208, 216, 224, 232, 240, 248, 255, 256, 263, 264};
        for (int i = 0; i < 13; i++) begin
            pix(xs[i], 400);
            cyc(1);
        end
        pix(200, 399); cyc(1);
        pix(200, 415); cyc(1);
        pix(200, 416); cyc(1);
        pix(200, 400);
    endtask

    initial begin
        int defeat_codes [7] = '{'h0D, 'h0E, 'h0F, 'h0E, 'h0A, 'h1D, 'h3F};
        bus.show = 1'b0;
        bus.hide = 1'b0;
        bus.word_sel = 2'd0;
        bus.DrawX = 10'd200;
        bus.DrawY = 10'd400;

        // Reset state
        cyc(3);
        Reset = 1'b0;
        cyc(2);
        check_en = 1'b1;
        lit("reset_busy", int'(bus.busy), 0);
        lit("reset_is_word", int'(bus.is_word), 0);
        lit("reset_n", int'(bus.n), 0);
        lit("reset_done", int'(bus.reveal_done), 0);
        sweep();

        // FIGHT! reveal
        do_show(0);
        do_tick();
        pix(200, 400);
        lit("fight_c0_is_word", int'(bus.is_word), 1);
        lit("fight_c0_n", int'(bus.n), 'h0F);
        pix(208, 400);
        lit("fight_c1_hidden", int'(bus.is_word), 0);
        for (int i = 0; i < 20; i++) begin
            do_tick();
            sweep();
        end
        pix(240, 400);
        lit("fight_bang_n", int'(bus.n), 'h3F);
        lit("fight_bang_vis", int'(bus.is_word), 1);
        cyc(2);
        ticks(3);
        lit("fight_done_once", done_cnt, 1);

        // DEFEAT! restarted while busy
        do_show(1);
        ticks(24);
        cyc(2);
        for (int i = 0; i < 7; i++) begin
            pix(200 + 8 * i, 400);
            lit($sformatf("defeat_n_%0d", i), int'(bus.n), defeat_codes[i]);
        end
        pix(256, 400);
        lit("defeat_x256", int'(bus.is_word), 0);
        pix(200, 416);
        lit("defeat_y416", int'(bus.is_word), 0);
        lit("defeat_done", done_cnt, 2);
        sweep();

        // FIGHT! to reveal_cnt=3, then VICTORY! with a coincident tick
        pix(200, 400);
        do_show(0);
        ticks(8);
        sweep();
        check_en = 1'b0;
        frame_clk = 1'b1;
        cyc(1);
        bus.word_sel = 2'd2;
        bus.show = 1'b1;
        cyc(1);
        bus.show = 1'b0;
        frame_clk = 1'b0;
        m_word = 2;
        m_busy = 1'b1;
        m_ticks = 0;
        cyc(2);
        check_en = 1'b1;
        pix(200, 400);
        lit("victory_n0", int'(bus.n), 'h1F);
        lit("victory_c0_vis", int'(bus.is_word), 1);
        pix(208, 400);
        lit("victory_c1_hidden", int'(bus.is_word), 0);
        ticks(3);
        lit("victory_tick_ignored", int'(bus.is_word), 0);
        do_tick();
        lit("victory_c1_shown", int'(bus.is_word), 1);
        ticks(24);
        cyc(2);
        lit("victory_done", done_cnt, 3);

        // Hold then blink
        pix(200, 400);
        ticks(59);
        lit("hold_end_vis", int'(bus.is_word), 1);
        do_tick();
        lit("blink_off", int'(bus.is_word), 0);
        ticks(29);
        lit("blink_off_end", int'(bus.is_word), 0);
        do_tick();
        lit("blink_on", int'(bus.is_word), 1);
        sweep();
        ticks(29);
        lit("blink_on_end", int'(bus.is_word), 1);
        do_tick();
        lit("blink_off2", int'(bus.is_word), 0);

        // hide and show together in BLINK: hide wins
        check_en = 1'b0;
        bus.word_sel = 2'd1;
        bus.show = 1'b1;
        bus.hide = 1'b1;
        cyc(1);
        bus.show = 1'b0;
        bus.hide = 1'b0;
        m_busy = 1'b0;
        check_en = 1'b1;
        lit("hide_busy", int'(bus.busy), 0);
        sweep();
        do_show(3);
        lit("reserved_busy", int'(bus.busy), 0);
        lit("reserved_n", int'(bus.n), 0);
        ticks(2);
        lit("reserved_no_done", done_cnt, 3);

        // Reset mid-REVEAL
        do_show(2);
        ticks(12);
        pix(224, 400);
        lit("pre_reset_c3_vis", int'(bus.is_word), 1);
        pix(200, 400);
        check_en = 1'b0;
        Reset = 1'b1;
        m_busy = 1'b0;
        m_word = 3;
        m_ticks = 0;
        cyc(1);
        lit("rst_busy", int'(bus.busy), 0);
        lit("rst_is_word", int'(bus.is_word), 0);
        Reset = 1'b0;
        cyc(2);
        check_en = 1'b1;
        lit("post_rst_busy", int'(bus.busy), 0);
        lit("post_rst_n", int'(bus.n), 0);
        ticks(2);
        sweep();
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
